serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial unsigned subtractor. Computes diff = a - b, LSB first, one bit per clock.
//   Inverse-direction companion of the combinational adder datapath (sum/carry) on the
//   ui_in/uo_out pins: borrow instead of carry, with a stored borrow instead of a ripple chain.
//   Sits behind the top-level pin wrapper; operands arrive via a valid/ready load port.
//   Result leaves via a valid/ready result port with diff, borrow and zero flags.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range 2..32
// PORTS
//   clk        in   1      single clock; all state updates on its rising edge
//   rst        in   1      synchronous reset, active-high; sampled on rising clk
//   in_valid   in   1      operands a/b valid
//   in_ready   out  1      block idle and able to accept operands
//   a          in   WIDTH  minuend (unsigned)
//   b          in   WIDTH  subtrahend (unsigned)
//   out_valid  out  1      diff/borrow/zero valid, held until out_ready
//   out_ready  in   1      consumer takes the result
//   diff       out  WIDTH  (a - b) mod 2^WIDTH
//   borrow     out  1      1 iff a < b (unsigned)
//   zero       out  1      1 iff diff == 0
//   busy       out  1      1 while in RUN
// BEHAVIOUR
//   - Reset (rst=1 at an edge): state=IDLE, counter=0, borrow reg=0, shift regs=0.
//     Outputs: diff=0, borrow=0, zero=0, out_valid=0, busy=0, in_ready=1.
//   - FSM IDLE -> RUN -> DONE -> IDLE.
//     * IDLE: in_ready=1. If in_valid at an edge: latch a/b into shift regs,
//       clear borrow reg and counter, go to RUN.
//     * RUN: busy=1, in_ready=0. Each edge: d=a0^b0^br; br'=(~a0&b0)|(~(a0^b0)&br).
//       Shift d into the result MSB; shift both operands right by 1; counter++.
//       On the edge where counter==WIDTH-1: go to DONE.
//     * DONE: out_valid=1; diff, borrow and zero are stable and driven from registers.
//       On an edge with out_ready=1: go to IDLE; out_valid drops next cycle.
//   - Latency: accept edge E0; out_valid is high from edge E_WIDTH onward.
//     WIDTH=8 -> result visible 8 cycles after acceptance.
//     Throughput: one operation per WIDTH+2 cycles with out_ready tied high.
//   - Handshake: no same-cycle bypass. in_ready=0 in RUN/DONE; in_valid there is ignored
//     and the operands are not captured. out_valid never drops without out_ready.
//     diff, borrow and zero hold their last values after the DONE->IDLE transition.
//   - zero is computed from the complete result register in DONE, not accumulated serially.
//   - Reset mid-operation (RUN or DONE): aborts the operation, returns to the reset state
//     and discards the partial result; no out_valid pulse.
//   - Arithmetic: fixed WIDTH bits, no extension.
//     The final borrow reg equals the borrow output (a<b). Wrap-around examples:
//     0-1 -> all ones with borrow=1; 0-0 -> 0 with zero=1.
//   - Counter width is $clog2(WIDTH); it never exceeds WIDTH-1.
// STRUCTURE
//   - Shared package serial_arith_pkg: state enum {IDLE, RUN, DONE} (2-bit encoding)
//     and a CNT_W function for $clog2(WIDTH). It is reused by a later serial adder.
//   - One sub-module: full_subtractor_cell (combinational, a/b/bin -> d/bout).
//     It is instantiated once; the FSM, counter and shift registers stay in the top.
// TESTING
//   1 WIDTH=8, a=0x5A, b=0x3C, out_ready=1 -> after 8 cycles diff=0x1E, borrow=0, zero=0.
//   2 a=0x00, b=0x01 -> diff=0xFF, borrow=1, zero=0;
//     a=0x80, b=0x80 -> diff=0x00, borrow=0, zero=1.
//   3 Accept a=0x10, b=0x01, hold out_ready=0 for 5 cycles:
//     out_valid stays 1 and diff stays 0x0F. Raise out_ready -> next cycle out_valid=0,
//     in_ready=1.
//   4 Assert in_valid with a=0xFF, b=0x00 during RUN of a=0x03, b=0x02:
//     result is 0x01; the second operand pair is not captured.
//   5 Assert rst at cycle 4 of RUN -> next cycle all outputs at reset values, in_ready=1.
//     A new op a=0x09, b=0x04 then gives 0x05.
//   6 Random sweep, 1000 ops, WIDTH=8 and WIDTH=16, with random out_ready.
//     Scoreboard checks (a-b) mod 2^WIDTH, borrow==(a<b) and zero==(diff==0).

Source files
------------

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared state encoding and counter sizing for bit-serial arithmetic blocks
package serial_arith_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int CNT_W(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/full_subtractor_cell.sv
// full_subtractor_cell: one-bit subtract with borrow-in and borrow-out
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial unsigned a - b with valid/ready operand and result ports
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             busy
);
  localparam int CW = CNT_W(WIDTH);
  state_t state;
  logic [WIDTH-1:0] sa, sb, sr, res;
  logic [CW-1:0] cnt;
  logic br, d, bo;
  full_subtractor_cell u_cell (.a(sa[0]), .b(sb[0]), .bin(br), .d(d), .bout(bo));
  assign res = {d, sr[WIDTH-1:1]};
  assign in_ready = state == IDLE;
  assign busy = state == RUN;
  // operand capture, one result bit per cycle, and result hand-off
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      br <= 1'b0;
      sa <= '0;
      sb <= '0;
      sr <= '0;
      diff <= '0;
      borrow <= 1'b0;
      zero <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sa <= a;
          sb <= b;
          br <= 1'b0;
          cnt <= '0;
          state <= RUN;
        end
        RUN: begin
          sr <= res;
          sa <= sa >> 1;
          sb <= sb >> 1;
          br <= bo;
          if (cnt == CW'(WIDTH - 1)) begin
            cnt <= '0;
            state <= DONE;
            diff <= res;
            borrow <= bo;
            zero <= ~|res;
            out_valid <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table, directed and scoreboarded random checks of serial_subtractor at WIDTH 8 and 16
module tb_serial_subtractor;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic iv8, ir8, ov8, or8, bo8, z8, bz8;
  logic [7:0] a8, b8, d8;
  logic iv16, ir16, ov16, or16, bo16, z16, bz16;
  logic [15:0] a16, b16, d16;
  int tests = 0, fails = 0;
  typedef struct {logic [31:0] d; logic bo; logic z;} exp_t;
  typedef struct {logic [7:0] a, b, d; logic bo, z;} vec_t;
  exp_t q8[$], q16[$];
  exp_t e8, e16;
  vec_t vecs[8];
  logic hold8;
  logic [7:0] hd8;

  serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .borrow(bo8), .zero(z8), .busy(bz8));
  serial_subtractor #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .diff(d16), .borrow(bo16), .zero(z16), .busy(bz16));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out", name);
  endtask

  // scoreboard for the 8-bit DUT, plus hold-while-stalled checks
  always @(negedge clk) begin
    if (hold8 && !rst) begin
      chk("hold_valid8", 32'(ov8), 32'd1);
      chk("hold_diff8", 32'(d8), 32'(hd8));
    end
    hold8 <= ov8 && !or8 && !rst;
    hd8 <= d8;
    if (ov8 && or8) begin
      if (q8.size() == 0) timeout("unexpected_result8");
      else begin
        e8 = q8.pop_front();
        chk("diff8", 32'(d8), e8.d);
        chk("borrow8", 32'(bo8), 32'(e8.bo));
        chk("zero8", 32'(z8), 32'(e8.z));
      end
    end
  end

  // scoreboard for the 16-bit DUT
  always @(negedge clk) begin
    if (ov16 && or16) begin
      if (q16.size() == 0) timeout("unexpected_result16");
      else begin
        e16 = q16.pop_front();
        chk("diff16", 32'(d16), e16.d);
        chk("borrow16", 32'(bo16), 32'(e16.bo));
        chk("zero16", 32'(z16), 32'(e16.z));
      end
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed, input logic eb, input logic ez);
    int k = 0;
    while (!ir8 && k < 100) begin @(posedge clk); #1; k++; end
    if (k == 100) timeout("in_ready8");
    a8 = a; b8 = b; iv8 = 1'b1;
    @(posedge clk);
    q8.push_back('{32'(ed), eb, ez});
    #1 iv8 = 1'b0;
  endtask

  task automatic drain8(input bit rnd);
    int k = 0;
    while (q8.size() != 0 && k < 500) begin
      or8 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1; k++;
    end
    or8 = 1'b1;
    if (k == 500) timeout("drain8");
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ed, input logic eb, input logic ez);
    int k = 0;
    while (!ir16 && k < 100) begin @(posedge clk); #1; k++; end
    if (k == 100) timeout("in_ready16");
    a16 = a; b16 = b; iv16 = 1'b1;
    @(posedge clk);
    q16.push_back('{32'(ed), eb, ez});
    #1 iv16 = 1'b0;
  endtask

  task automatic drain16(input bit rnd);
    int k = 0;
    while (q16.size() != 0 && k < 500) begin
      or16 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1; k++;
    end
    or16 = 1'b1;
    if (k == 500) timeout("drain16");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] ra, rb;
    logic [15:0] sa, sb;
    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[5] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[7] = '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b0};
    rst = 1'b1; iv8 = 0; or8 = 1; a8 = 0; b8 = 0; iv16 = 0; or16 = 1; a16 = 0; b16 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(ov8), 0); chk("rst_diff", 32'(d8), 0); chk("rst_borrow", 32'(bo8), 0);
    chk("rst_zero", 32'(z8), 0); chk("rst_busy", 32'(bz8), 0); chk("rst_in_ready", 32'(ir8), 1);
    @(posedge clk); #1 rst = 1'b0;
    // latency: result visible 8 edges after acceptance
    send8(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
    n = 0;
    while (!ov8 && n < 50) begin @(posedge clk); @(negedge clk); n++; end
    chk("latency8", n, 8);
    @(posedge clk); #1;
    drain8(0);
    for (int i = 0; i < 8; i++) begin
      send8(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, vecs[i].z);
      drain8(0);
    end
    // result held under back-pressure
    or8 = 1'b0;
    send8(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
    n = 0;
    while (!ov8 && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) timeout("valid_stall");
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(ov8), 1);
      chk("stall_diff", 32'(d8), 32'h0F);
    end
    @(posedge clk); #1 or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_valid", 32'(ov8), 0);
    chk("release_in_ready", 32'(ir8), 1);
    @(posedge clk); #1;
    // operands offered during RUN are ignored
    send8(8'h03, 8'h02, 8'h01, 1'b0, 1'b0);
    a8 = 8'hFF; b8 = 8'h00; iv8 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("run_busy", 32'(bz8), 1);
      chk("run_in_ready", 32'(ir8), 0);
    end
    @(posedge clk); #1 iv8 = 1'b0;
    drain8(0);
    repeat (12) begin @(posedge clk); #1; end
    chk("no_second_op", 32'(ov8), 0);
    // reset in the middle of RUN
    send8(8'h77, 8'h11, 8'h66, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    q8.delete();
    @(posedge clk);
    @(negedge clk);
    chk("abort_valid", 32'(ov8), 0); chk("abort_diff", 32'(d8), 0); chk("abort_borrow", 32'(bo8), 0);
    chk("abort_zero", 32'(z8), 0); chk("abort_busy", 32'(bz8), 0); chk("abort_in_ready", 32'(ir8), 1);
    @(posedge clk); #1 rst = 1'b0;
    send8(8'h09, 8'h04, 8'h05, 1'b0, 1'b0);
    drain8(0);
    // random sweeps with random back-pressure
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = (i % 8 == 0) ? ra : 8'($urandom);
      send8(ra, rb, ra - rb, ra < rb, ra == rb);
      drain8(1);
    end
    for (int i = 0; i < 1000; i++) begin
      sa = 16'($urandom);
      sb = (i % 8 == 0) ? sa : 16'($urandom);
      send16(sa, sb, sa - sb, sa < sb, sa == sb);
      drain16(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
